agen_issue_sel: RTL and testbench
=================================

Name: agen_issue_sel

Overview:
- Parametrised address-generator issue selector for the memory pipeline.
- Picks up to NUM_AGEN ready memory ops from the issue queue per cycle, oldest-first relative to the queue head.
- Tracks per-AGEN occupancy with latency counters and suppresses re-issue of an entry picked in the previous cycle.
- Sits between the issue-queue readiness logic and the AGEN units; outputs are registered one-hot issue vectors per AGEN.

Parameters:
- IQ_ENTRIES, 8, issue-queue depth; power of two, at least 2.
- NUM_AGEN, 2, number of address generators; 1 to 4.
- AGEN_LAT, 2, cycles an AGEN stays busy after an issue; 1 to 15.
- QIDW, $clog2(IQ_ENTRIES), queue index width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ce  input  1  clock enable; all state holds when low.
- flush  input  1  synchronous pipeline flush.
- allow_issue  input  NUM_AGEN  per-AGEN issue permission.
- agen_stall  input  NUM_AGEN  per-AGEN downstream stall; freezes that AGEN's counter.
- head  input  QIDW  index of the oldest queue entry.
- could_issue  input  IQ_ENTRIES  entry operands ready.
- iq_mem  input  IQ_ENTRIES  entry is a memory op.
- iq_prior_sync  input  IQ_ENTRIES  an older sync is still pending.
- issue  output  NUM_AGEN*IQ_ENTRIES  registered one-hot (or zero) issue vector per AGEN; AGEN k occupies bits [k*IQ_ENTRIES +: IQ_ENTRIES].
- agen_busy  output  NUM_AGEN  AGEN k counter non-zero.

Behaviour:
Reset (rst_n low, asynchronous):
- issue = 0, all busy counters = 0, agen_busy = 0.
- The last-issued mask is cleared.
- Reset applied mid-operation discards any in-flight occupancy.

Eligibility (combinational):
- Entry n is eligible iff could_issue[n] & iq_mem[n] & !iq_prior_sync[n] & !last_issued[n].
- last_issued is the OR of all AGEN slices of the current issue register.

Age and selection:
- age(n) = (n - head) mod IQ_ENTRIES; age 0 is oldest. Wrap is handled by QIDW-bit unsigned subtraction.
- AGEN k is idle iff cnt[k] == 0 and allow_issue[k] and !agen_stall[k].
- AGENs are served in index order 0..NUM_AGEN-1. Each idle AGEN takes the eligible entry with the smallest age not already taken by a lower-index AGEN.
- A non-idle AGEN takes nothing, and its candidate remains available to higher-index AGENs.
- At most one bit is set per slice, and no entry appears in two slices.

Registered update (ce high, not flush):
- issue <= selection.
- For each AGEN that selected an entry: cnt[k] <= AGEN_LAT-1.
- Else, if cnt[k] != 0 and !agen_stall[k]: cnt[k] <= cnt[k]-1.
- With AGEN_LAT=1 the counter stays 0, so back-to-back issue every cycle is allowed.

Latency and timing:
- Selection is visible on issue one cycle after inputs are presented.
- An entry issued in cycle t is excluded in cycle t+1 even if could_issue has not yet dropped.

Flush and clock enable:
- Flush (ce high) forces issue <= 0 and all cnt <= 0, and wins over a simultaneous selection.
- ce low: issue, counters and mask all hold; flush is ignored.

Boundary cases:
- No eligible entry: zero slice, counter decrements normally.
- All entries eligible: the lowest-index idle AGEN gets the head entry.
- head = IQ_ENTRIES-1: entry IQ_ENTRIES-1 is oldest, then 0, 1, and so on.

Optional Feature:
AGEN_ISSUE_STATS_EN
- Defined: adds output issue_cnt (NUM_AGEN*16), one 16-bit saturating counter per AGEN.
  - Each counter increments on every registered issue to that AGEN.
  - Cleared by reset only; flush does not clear it; holds at 16'hFFFF.
- Not defined: the port and the counters are absent; no other behaviour changes.

Test Plan:
- Reset: rst_n low mid-run with cnt[0]=1 -> issue=0 and agen_busy=0 immediately, before any clock edge.
- Wrap ordering: IQ_ENTRIES=8, head=6, eligible entries {1,5,7} -> AGEN0 gets entry 7, AGEN1 gets entry 1.
- Busy counter: AGEN_LAT=3, entry 2 eligible every cycle -> AGEN0 issues entry 2 at t+1; agen_busy[0] high for 2 cycles; with allow_issue[1]=0, next AGEN0 issue at t+4.
- Sync block and double-issue guard:
  - iq_prior_sync[3]=1 with entry 3 otherwise eligible -> never issued.
  - could_issue[4] held high for 2 cycles -> entry 4 issued once.
- Flush versus issue: flush=1 with eligible entry 0 -> issue=0 next cycle, cnt=0; with ce=0, flush=1 -> outputs hold.
- Stats (AGEN_ISSUE_STATS_EN): 65540 AGEN0 issues -> issue_cnt[15:0]=16'hFFFF; flush leaves the value unchanged.

Source files
------------

// File: rtl/agen_issue_sel_if.sv
// Issue-selector bus: queue readiness, per-AGEN controls, registered issue vectors.
// With AGEN_ISSUE_STATS_EN defined the bus also carries per-AGEN issue counters.
interface agen_issue_sel_if #(
   parameter int IQ_ENTRIES = 8,
   parameter int NUM_AGEN   = 2,
   parameter int QIDW       = $clog2(IQ_ENTRIES)
);
   logic                           ce;
   logic                           flush;
   logic [NUM_AGEN-1:0]            allow_issue;
   logic [NUM_AGEN-1:0]            agen_stall;
   logic [QIDW-1:0]                head;
   logic [IQ_ENTRIES-1:0]          could_issue;
   logic [IQ_ENTRIES-1:0]          iq_mem;
   logic [IQ_ENTRIES-1:0]          iq_prior_sync;
   logic [NUM_AGEN*IQ_ENTRIES-1:0] issue;
   logic [NUM_AGEN-1:0]            agen_busy;
`ifdef AGEN_ISSUE_STATS_EN
   logic [NUM_AGEN*16-1:0]         issue_cnt;

   modport master (
      output ce, flush, allow_issue, agen_stall, head, could_issue, iq_mem, iq_prior_sync,
      input  issue, agen_busy, issue_cnt
   );
   modport slave (
      input  ce, flush, allow_issue, agen_stall, head, could_issue, iq_mem, iq_prior_sync,
      output issue, agen_busy, issue_cnt
   );
`else
   modport master (
      output ce, flush, allow_issue, agen_stall, head, could_issue, iq_mem, iq_prior_sync,
      input  issue, agen_busy
   );
   modport slave (
      input  ce, flush, allow_issue, agen_stall, head, could_issue, iq_mem, iq_prior_sync,
      output issue, agen_busy
   );
`endif
endinterface

// File: rtl/agen_issue_sel.sv
// Address-generator issue selector: oldest-first pick of ready memory ops,
// one registered one-hot issue slice per AGEN, per-AGEN occupancy counters.
// Optional macro AGEN_ISSUE_STATS_EN adds a 16-bit saturating issue counter per AGEN.

// Per-AGEN occupancy counter (and optional issue statistics).
module agen_issue_sel_lane #(
   parameter int AGEN_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ce,
   input  logic        flush,
   input  logic        pick,
   input  logic        stall,
   output logic        busy
`ifdef AGEN_ISSUE_STATS_EN
   ,
   output logic [15:0] issue_cnt
`endif
);
   localparam logic [3:0] LOAD = 4'(AGEN_LAT - 1);

   logic [3:0] cnt;

   // Load on issue, count down when not stalled; flush empties the AGEN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (ce) begin
         if (flush)
            cnt <= '0;
         else if (pick)
            cnt <= LOAD;
         else if (cnt != 4'd0 && !stall)
            cnt <= cnt - 4'd1;
      end
   end

   assign busy = (cnt != 4'd0);

`ifdef AGEN_ISSUE_STATS_EN
   // Count issues that actually land in the issue register; flush does not clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         issue_cnt <= '0;
      else if (ce && !flush && pick && issue_cnt != 16'hFFFF)
         issue_cnt <= issue_cnt + 16'd1;
   end
`endif
endmodule

module agen_issue_sel #(
   parameter int IQ_ENTRIES = 8,
   parameter int NUM_AGEN   = 2,
   parameter int AGEN_LAT   = 2,
   parameter int QIDW       = $clog2(IQ_ENTRIES)
) (
   input logic            clk,
   input logic            rst_n,
   agen_issue_sel_if.slave bus
);
   logic [NUM_AGEN-1:0][IQ_ENTRIES-1:0] sel;
   logic [NUM_AGEN-1:0][IQ_ENTRIES-1:0] issue_q;
   logic [IQ_ENTRIES-1:0]               last_issued;
   logic [IQ_ENTRIES-1:0]               elig;
   logic [NUM_AGEN-1:0]                 busy;
   logic [NUM_AGEN-1:0]                 idle;
`ifdef AGEN_ISSUE_STATS_EN
   logic [NUM_AGEN-1:0][15:0]           stat_cnt;
`endif

   // Entries issued last cycle are masked so a slow could_issue drop cannot double-issue.
   always_comb begin
      last_issued = '0;
      for (int k = 0; k < NUM_AGEN; k++)
         last_issued = last_issued | issue_q[k];
   end

   assign elig = bus.could_issue & bus.iq_mem & ~bus.iq_prior_sync & ~last_issued;
   assign idle = ~busy & bus.allow_issue & ~bus.agen_stall;

   // Walk AGENs in index order; each idle one takes the oldest untaken eligible entry.
   // Scanning by age from head makes the wrap of (n - head) implicit.
   always_comb begin
      logic [IQ_ENTRIES-1:0] taken;
      logic                  found;
      logic [QIDW-1:0]       idx;
      sel   = '0;
      taken = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_AGEN; k++) begin
         found = 1'b0;
         for (int a = 0; a < IQ_ENTRIES; a++) begin
            idx = bus.head + QIDW'(a);
            if (idle[k] && !found && elig[idx] && !taken[idx]) begin
               sel[k][idx] = 1'b1;
               taken[idx]  = 1'b1;
               found       = 1'b1;
            end
         end
      end
   end

   // Issue register; flush wins over a same-cycle selection, ce low holds everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         issue_q <= '0;
      else if (bus.ce)
         issue_q <= bus.flush ? '0 : sel;
   end

   for (genvar k = 0; k < NUM_AGEN; k++) begin : g_lane
      agen_issue_sel_lane #(.AGEN_LAT(AGEN_LAT)) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .ce        (bus.ce),
         .flush     (bus.flush),
         .pick      (|sel[k]),
         .stall     (bus.agen_stall[k]),
         .busy      (busy[k])
`ifdef AGEN_ISSUE_STATS_EN
         ,
         .issue_cnt (stat_cnt[k])
`endif
      );
   end

   assign bus.issue     = issue_q;
   assign bus.agen_busy = busy;
`ifdef AGEN_ISSUE_STATS_EN
   assign bus.issue_cnt = stat_cnt;
`endif
endmodule

// File: tb/tb_agen_issue_sel.sv
// Directed bench for agen_issue_sel (IQ_ENTRIES=8, NUM_AGEN=2, AGEN_LAT=3).
// With AGEN_ISSUE_STATS_EN a second instance (AGEN_LAT=1) exercises counter saturation.
module tb_agen_issue_sel;
   localparam int IQ = 8;
   localparam int NA = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   agen_issue_sel_if #(.IQ_ENTRIES(IQ), .NUM_AGEN(NA)) bus ();
   agen_issue_sel #(.IQ_ENTRIES(IQ), .NUM_AGEN(NA), .AGEN_LAT(3)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

`ifdef AGEN_ISSUE_STATS_EN
   agen_issue_sel_if #(.IQ_ENTRIES(IQ), .NUM_AGEN(NA)) bus1 ();
   agen_issue_sel #(.IQ_ENTRIES(IQ), .NUM_AGEN(NA), .AGEN_LAT(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );
`endif

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] rdy, input logic [7:0] mem, input logic [7:0] sync,
                        input logic [2:0] h, input logic [1:0] allow, input logic [1:0] stall);
      bus.could_issue   = rdy;
      bus.iq_mem        = mem;
      bus.iq_prior_sync = sync;
      bus.head          = h;
      bus.allow_issue   = allow;
      bus.agen_stall    = stall;
   endtask

   initial begin
      bus.ce    = 1'b1;
      bus.flush = 1'b0;
      drive(8'h00, 8'h00, 8'h00, 3'd0, 2'b11, 2'b00);
`ifdef AGEN_ISSUE_STATS_EN
      bus1.ce            = 1'b1;
      bus1.flush         = 1'b0;
      bus1.could_issue   = '0;
      bus1.iq_mem        = '0;
      bus1.iq_prior_sync = '0;
      bus1.head          = '0;
      bus1.allow_issue   = '0;
      bus1.agen_stall    = '0;
`endif
      #12;
      chk("rst_issue", 64'(bus.issue), 64'h0);
      chk("rst_busy", 64'(bus.agen_busy), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // head=6, entries {1,5,7}: ages 3,7,1 -> AGEN0=7, AGEN1=1
      drive(8'hA2, 8'hA2, 8'h00, 3'd6, 2'b11, 2'b00);
      tick();
      chk("wrap_issue", 64'(bus.issue), 64'h0280);
      chk("wrap_busy", 64'(bus.agen_busy), 64'h3);
      drive(8'h00, 8'h00, 8'h00, 3'd0, 2'b11, 2'b00);
      tick();
      chk("empty_issue", 64'(bus.issue), 64'h0);
      chk("cnt1_busy", 64'(bus.agen_busy), 64'h3);
      tick();
      chk("drain_busy", 64'(bus.agen_busy), 64'h0);

      // AGEN_LAT=3, entry 2 always ready, AGEN1 disallowed: issues at t+1 and t+4
      drive(8'h04, 8'h04, 8'h00, 3'd0, 2'b01, 2'b00);
      tick();
      chk("lat_issue1", 64'(bus.issue), 64'h0004);
      chk("lat_busy1", 64'(bus.agen_busy), 64'h1);
      tick();
      chk("lat_gap2", 64'(bus.issue), 64'h0);
      chk("lat_busy2", 64'(bus.agen_busy), 64'h1);
      tick();
      chk("lat_gap3", 64'(bus.issue), 64'h0);
      chk("lat_busy3", 64'(bus.agen_busy), 64'h0);
      tick();
      chk("lat_issue4", 64'(bus.issue), 64'h0004);
      drive(8'h00, 8'h00, 8'h00, 3'd0, 2'b11, 2'b00);
      repeat (3) tick();

      // entry 1 not mem, entry 2 not ready, entry 3 behind a sync: nothing issues
      drive(8'h0A, 8'h0C, 8'h08, 3'd0, 2'b11, 2'b00);
      tick();
      chk("sync_blk1", 64'(bus.issue), 64'h0);
      tick();
      chk("sync_blk2", 64'(bus.issue), 64'h0);

      // entry 4 ready two cycles: AGEN1 is idle but must not re-issue it
      drive(8'h10, 8'h10, 8'h00, 3'd0, 2'b11, 2'b00);
      tick();
      chk("once_issue", 64'(bus.issue), 64'h0010);
      tick();
      chk("no_double", 64'(bus.issue), 64'h0);
      drive(8'h00, 8'h00, 8'h00, 3'd0, 2'b11, 2'b00);
      repeat (3) tick();

      // all eligible, head=3: AGEN0=3, AGEN1=4; with AGEN0 disallowed AGEN1 gets head
      drive(8'hFF, 8'hFF, 8'h00, 3'd3, 2'b11, 2'b00);
      tick();
      chk("all_elig", 64'(bus.issue), 64'h1008);
      drive(8'h00, 8'h00, 8'h00, 3'd0, 2'b11, 2'b00);
      repeat (3) tick();
      drive(8'hFF, 8'hFF, 8'h00, 3'd3, 2'b10, 2'b00);
      tick();
      chk("skip_agen0", 64'(bus.issue), 64'h0800);
      drive(8'h00, 8'h00, 8'h00, 3'd0, 2'b11, 2'b00);
      repeat (3) tick();

      // stall freezes the counter
      drive(8'h01, 8'h01, 8'h00, 3'd0, 2'b01, 2'b00);
      tick();
      chk("stall_issue", 64'(bus.issue), 64'h0001);
      drive(8'h00, 8'h00, 8'h00, 3'd0, 2'b01, 2'b01);
      repeat (2) tick();
      chk("stall_hold", 64'(bus.agen_busy), 64'h1);
      drive(8'h00, 8'h00, 8'h00, 3'd0, 2'b01, 2'b00);
      tick();
      chk("stall_rel1", 64'(bus.agen_busy), 64'h1);
      tick();
      chk("stall_rel2", 64'(bus.agen_busy), 64'h0);

      // flush beats selection; ce low holds state and ignores flush
      drive(8'h01, 8'h01, 8'h00, 3'd0, 2'b11, 2'b00);
      bus.flush = 1'b1;
      tick();
      chk("flush_issue", 64'(bus.issue), 64'h0);
      chk("flush_busy", 64'(bus.agen_busy), 64'h0);
      bus.flush = 1'b0;
      tick();
      chk("post_flush", 64'(bus.issue), 64'h0001);
      drive(8'h00, 8'h00, 8'h00, 3'd0, 2'b11, 2'b00);
      bus.ce    = 1'b0;
      bus.flush = 1'b1;
      tick();
      chk("ce_hold_iss", 64'(bus.issue), 64'h0001);
      chk("ce_hold_bsy", 64'(bus.agen_busy), 64'h1);
      bus.ce    = 1'b1;
      bus.flush = 1'b0;
      tick();
      chk("ce_resume", 64'(bus.agen_busy), 64'h1);
      tick();
      chk("ce_drain", 64'(bus.agen_busy), 64'h0);

      // async reset mid-run with cnt[0]=1 and a live issue slice
      drive(8'h20, 8'h20, 8'h00, 3'd0, 2'b01, 2'b00);
      tick();
      chk("pre_rst1", 64'(bus.issue), 64'h0020);
      drive(8'h60, 8'h60, 8'h00, 3'd0, 2'b11, 2'b00);
      tick();
      chk("pre_rst2", 64'(bus.issue), 64'h4000);
      chk("pre_rst_bsy", 64'(bus.agen_busy), 64'h3);
      rst_n = 1'b0;
      #2;
      chk("arst_issue", 64'(bus.issue), 64'h0);
      chk("arst_busy", 64'(bus.agen_busy), 64'h0);
      drive(8'h00, 8'h00, 8'h00, 3'd0, 2'b11, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst", 64'(bus.issue), 64'h0);

`ifdef AGEN_ISSUE_STATS_EN
      // AGEN_LAT=1, all ready: AGEN0 alternates entries 0/1 and issues every cycle
      bus1.could_issue = 8'hFF;
      bus1.iq_mem      = 8'hFF;
      bus1.allow_issue = 2'b01;
      repeat (10) tick();
      chk("stat_10", 64'(bus1.issue_cnt[15:0]), 64'd10);
      chk("stat_a1", 64'(bus1.issue_cnt[31:16]), 64'd0);
      repeat (65530) tick();
      chk("stat_sat", 64'(bus1.issue_cnt[15:0]), 64'hFFFF);
      bus1.flush = 1'b1;
      tick();
      chk("stat_flush", 64'(bus1.issue_cnt[15:0]), 64'hFFFF);
      chk("stat_fl_iss", 64'(bus1.issue), 64'h0);
      bus1.flush = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
